led_sched: RTL and testbench

Board LED display scheduler. Takes the raw push-buttons and slide switches, conditions the buttons, and drives the 16 board LEDs from one of four display modes: switch pass-through, rotating chaser, binary counter and blink. Sits between the board I/O pins and the LED bank; all pattern timing is derived from an internal prescaler.

---
 rtl/led_sched_pkg.sv | 38 +++
 rtl/led_sched_if.sv | 23 ++
 rtl/led_sched_btn_cond.sv | 115 +++++++++++
 rtl/led_sched.sv | 156 +++++++++++++++
 tb/tb_led_sched.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/led_sched_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg : shared definitions for the board LED display scheduler.
//
// Contents:
//    mode_t        display mode enum (PASS / CHASE / COUNT / BLINK)
//    BTN_*         index of each push-button function within btn[4:0]
//    LED_*         bit offsets of the fields packed into ledr[15:0]
//    CHASE_INIT    value the chaser restarts from
//    rotate8()     one-step rotation of the chaser pattern
// -----------------------------------------------------------------------------
package led_pkg;

   typedef enum logic [1:0] {
      MODE_PASS  = 2'd0,
      MODE_CHASE = 2'd1,
      MODE_COUNT = 2'd2,
      MODE_BLINK = 2'd3
   } mode_t;

   localparam int NUM_BTN  = 5;
   localparam int BTN_NEXT = 0;
   localparam int BTN_PREV = 1;
   localparam int BTN_RUN  = 2;
   localparam int BTN_STEP = 3;
   localparam int BTN_CLR  = 4;

   localparam int LED_MODE_LSB = 14;
   localparam int LED_RUN_BIT  = 13;
   localparam int LED_LVL_LSB  = 8;

   localparam logic [7:0] CHASE_INIT = 8'h01;

   // Rotate left (toward the MSB) when right is 0, otherwise rotate right.
   function automatic logic [7:0] rotate8(input logic [7:0] v, input logic right);
      return right ? {v[0], v[7:1]} : {v[6:0], v[7]};
   endfunction

endpackage

// File: rtl/led_sched_if.sv
// -----------------------------------------------------------------------------
// led_sched_if : board-side pins of the LED scheduler.
//
// Signals:
//    btn   [4:0]   raw push-buttons, 1 = pressed (driven by the board)
//    sw    [7:0]   slide switches (driven by the board)
//    ledr  [15:0]  LED drive (driven by the scheduler)
//
// Modports:
//    master  the board / test environment side
//    slave   the scheduler side
// -----------------------------------------------------------------------------
interface led_sched_if;
   import led_pkg::*;

   logic [NUM_BTN-1:0] btn;
   logic [7:0]         sw;
   logic [15:0]        ledr;

   modport master (output btn, output sw, input ledr);
   modport slave  (input btn, input sw, output ledr);

endinterface

// File: rtl/led_sched_btn_cond.sv
// -----------------------------------------------------------------------------
// btn_cond : push-button conditioning (synchronizer, debouncer, edge detector).
//
// Parameters:
//    WIDTH     number of buttons
//    DEB_LEN   stable cycles needed before the debounced level flips
//
// Ports:
//    clk       system clock
//    rst       synchronous active-low reset
//    btn_raw   asynchronous button inputs, 1 = pressed
//    level     debounced button levels
//    press     one-cycle pulse per press (rising edge of level)
//
// Build option: define LED_SCHED_DEBOUNCE_EN to include the per-bit debounce
// counters; otherwise the debounced level is a registered copy of the
// synchronized level and DEB_LEN has no effect.
// -----------------------------------------------------------------------------
module btn_cond
   import led_pkg::*;
#(
   parameter int WIDTH   = NUM_BTN,
   parameter int DEB_LEN = 20000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] btn_raw,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] press
);

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] armed;
   logic [1:0]       sync_vld;

   // Two-flop synchronizer. sync_vld fills with ones behind it so we know
   // when sync2 holds a real sample rather than its reset value.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1    <= '0;
         sync2    <= '0;
         sync_vld <= '0;
      end else begin
         sync1    <= btn_raw;
         sync2    <= sync1;
         sync_vld <= {sync_vld[0], 1'b1};
      end
   end

   // A button only becomes armed once it has been seen released after reset,
   // so a button held through reset release never produces a press.
   always_ff @(posedge clk) begin
      if (!rst) begin
         armed <= '0;
      end else if (sync_vld[1]) begin
         armed <= armed | ~sync2;
      end
   end

`ifdef LED_SCHED_DEBOUNCE_EN
   localparam int DEB_W = (DEB_LEN < 1) ? 1 : $clog2(DEB_LEN + 1);

   logic [DEB_W-1:0] deb_cnt [WIDTH];

   // Per-bit debounce: the counter runs only while the synchronized input
   // disagrees with the debounced level and restarts on any agreement; the
   // level follows the input once the disagreement has lasted DEB_LEN cycles.
   always_ff @(posedge clk) begin
      if (!rst) begin
         level <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            deb_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync2[i] == level[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_W'(DEB_LEN)) begin
               level[i]   <= sync2[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end
`else
   logic unused_deb_len;
   assign unused_deb_len = (DEB_LEN >= 1);

   // Without debouncing the level is a registered copy of the synchronized
   // input, keeping the press latency the same shape as the debounced build.
   always_ff @(posedge clk) begin
      if (!rst) begin
         level <= '0;
      end else begin
         level <= sync2;
      end
   end
`endif

   // Edge detector history; releases never pulse because only 0->1 counts.
   always_ff @(posedge clk) begin
      if (!rst) begin
         prev <= '0;
      end else begin
         prev <= level;
      end
   end

   assign press = level & ~prev & armed;

endmodule

// File: rtl/led_sched.sv
// -----------------------------------------------------------------------------
// led_sched : board LED display scheduler.
//
// Conditions the push-buttons and drives the 16 board LEDs from one of four
// display modes (switch pass-through, rotating chaser, binary counter, blink),
// all paced by an internal prescaler.
//
// Parameters:
//    TICK_DIV  clock cycles per pattern tick (>= 2)
//    DEB_LEN   debounce length in cycles (>= 1)
//
// Ports:
//    clk       system clock
//    rst       synchronous active-low reset
//    io        led_sched_if.slave : btn[4:0] in, sw[7:0] in, ledr[15:0] out
//
// Build option: LED_SCHED_DEBOUNCE_EN enables button debouncing in btn_cond.
// -----------------------------------------------------------------------------
module led_sched
   import led_pkg::*;
#(
   parameter int TICK_DIV = 5000000,
   parameter int DEB_LEN  = 20000
) (
   input  logic          clk,
   input  logic          rst,
   led_sched_if.slave    io
);

   localparam int             CNT_W   = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   logic [NUM_BTN-1:0] level;
   logic [NUM_BTN-1:0] press;

   mode_t             mode;
   mode_t             mode_nxt;
   logic              mode_chg;
   logic              running;
   logic [CNT_W-1:0]  cnt;
   logic [7:0]        chase;
   logic [7:0]        count;
   logic              phase;
   logic              clr;
   logic              run_tick;
   logic              step_tick;
   logic              tick;
   logic [15:0]       ledr_nxt;
   logic [15:0]       ledr_q;

   btn_cond #(
      .WIDTH   (NUM_BTN),
      .DEB_LEN (DEB_LEN)
   ) u_btn_cond (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (io.btn),
      .level   (level),
      .press   (press)
   );

   // Mode state register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mode <= MODE_PASS;
      end else begin
         mode <= mode_nxt;
      end
   end

   // Next mode: next and previous cancel each other when pressed together,
   // and both directions wrap around the four modes.
   always_comb begin
      mode_nxt = mode;
      mode_chg = 1'b0;
      if (press[BTN_NEXT] && !press[BTN_PREV]) begin
         mode_nxt = mode_t'(2'(mode + 2'd1));
         mode_chg = 1'b1;
      end else if (press[BTN_PREV] && !press[BTN_NEXT]) begin
         mode_nxt = mode_t'(2'(mode - 2'd1));
         mode_chg = 1'b1;
      end
   end

   // A step press only counts while paused and not alongside a run/pause
   // press, so toggling the run state always wins over stepping.
   assign clr       = press[BTN_CLR];
   assign run_tick  = running && (cnt == CNT_MAX);
   assign step_tick = !running && press[BTN_STEP] && !press[BTN_RUN];
   assign tick      = run_tick || step_tick;

   // Run/pause flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         running <= 1'b1;
      end else if (press[BTN_RUN]) begin
         running <= ~running;
      end
   end

   // Prescaler and pattern registers. A mode change or clear restarts every
   // pattern and the prescaler, swallowing any tick of that same cycle; only
   // the register that belongs to the current mode advances on a tick.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt   <= '0;
         chase <= CHASE_INIT;
         count <= '0;
         phase <= 1'b0;
      end else if (mode_chg || clr) begin
         cnt   <= '0;
         chase <= CHASE_INIT;
         count <= '0;
         phase <= 1'b0;
      end else begin
         if (running) begin
            cnt <= run_tick ? '0 : cnt + 1'b1;
         end
         if (tick) begin
            case (mode)
               MODE_CHASE: chase <= rotate8(chase, io.sw[7]);
               MODE_COUNT: count <= count + 8'd1;
               MODE_BLINK: phase <= ~phase;
               default:    ;
            endcase
         end
      end
   end

   // Pack status fields and the selected pattern into the LED word.
   always_comb begin
      ledr_nxt = '0;
      ledr_nxt[LED_MODE_LSB +: 2]      = mode;
      ledr_nxt[LED_RUN_BIT]            = running;
      ledr_nxt[LED_LVL_LSB +: NUM_BTN] = level;
      case (mode)
         MODE_PASS:  ledr_nxt[7:0] = io.sw;
         MODE_CHASE: ledr_nxt[7:0] = chase;
         MODE_COUNT: ledr_nxt[7:0] = count;
         MODE_BLINK: ledr_nxt[7:0] = phase ? io.sw : 8'h00;
         default:    ledr_nxt[7:0] = 8'h00;
      endcase
   end

   // Registered LED drive; reset shows PASS mode, running, everything else dark.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ledr_q <= 16'h2000;
      end else begin
         ledr_q <= ledr_nxt;
      end
   end

   assign io.ledr = ledr_q;

endmodule

// File: tb/tb_led_sched.sv
// -----------------------------------------------------------------------------
// tb_led_sched : directed self-checking bench for led_sched with TICK_DIV=4
// and DEB_LEN=3. Builds with or without LED_SCHED_DEBOUNCE_EN; the press
// latency and hold time adapt to the build.
// -----------------------------------------------------------------------------
module tb_led_sched;
   import led_pkg::*;

   localparam int TICK_DIV = 4;
   localparam int DEB_LEN  = 3;
`ifdef LED_SCHED_DEBOUNCE_EN
   localparam int LAT       = 3 + DEB_LEN;
   localparam int HOLD      = DEB_LEN + 2;
   localparam int PAUSE_CNT = 3;
`else
   localparam int LAT       = 3;
   localparam int HOLD      = 1;
   localparam int PAUSE_CNT = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   passes = 0;

   led_sched_if bus();

   led_sched #(
      .TICK_DIV (TICK_DIV),
      .DEB_LEN  (DEB_LEN)
   ) dut (
      .clk (clk),
      .rst (rst),
      .io  (bus)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs === exp) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, leaving time 1 unit after the last one.
   task automatic stepCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Press the buttons in mask and return 1 unit after the edge at which the
   // scheduler state reacts; ledr shows the reaction one edge later.
   task automatic applyStimulus(input logic [4:0] mask);
      bus.btn = bus.btn | mask;
      for (int k = 0; k <= LAT; k++) begin
         @(posedge clk);
         #1;
         if (k == HOLD - 1) bus.btn = bus.btn & ~mask;
      end
   endtask

   function automatic logic [15:0] modeOf(input logic [15:0] l);
      return {14'd0, l[15:14]};
   endfunction

   function automatic logic [15:0] runOf(input logic [15:0] l);
      return {15'd0, l[13]};
   endfunction

   function automatic logic [15:0] lowOf(input logic [15:0] l);
      return {8'd0, l[7:0]};
   endfunction

   initial begin
      bus.btn = '0;
      bus.sw  = 8'hA5;

      // Reset and pass-through.
      stepCycles(3);
      checkOutput("reset_ledr", bus.ledr, 16'h2000);
      rst = 1'b1;
      stepCycles(1);
      checkOutput("pass_a5", bus.ledr, 16'h20A5);

      // Chaser, rotating left.
      bus.sw = 8'h25;
      stepCycles(8);
      applyStimulus(5'b00001);
      stepCycles(1);
      checkOutput("chase_mode", modeOf(bus.ledr), 16'd1);
      checkOutput("chase_init", lowOf(bus.ledr), 16'h0001);
      stepCycles(4);
      checkOutput("chase_l1", lowOf(bus.ledr), 16'h0002);
      stepCycles(4);
      checkOutput("chase_l2", lowOf(bus.ledr), 16'h0004);

      // Chaser, rotating right after a clear.
      bus.sw = 8'h80;
      stepCycles(8);
      applyStimulus(5'b10000);
      stepCycles(1);
      checkOutput("clr_keep_mode", modeOf(bus.ledr), 16'd1);
      checkOutput("chase_r0", lowOf(bus.ledr), 16'h0001);
      stepCycles(4);
      checkOutput("chase_r1", lowOf(bus.ledr), 16'h0080);
      stepCycles(4);
      checkOutput("chase_r2", lowOf(bus.ledr), 16'h0040);

      // Counter wrap.
      bus.sw = 8'h00;
      stepCycles(8);
      applyStimulus(5'b00001);
      stepCycles(1);
      checkOutput("count_mode", modeOf(bus.ledr), 16'd2);
      checkOutput("count_init", lowOf(bus.ledr), 16'h0000);
      stepCycles(1020);
      checkOutput("count_ff", lowOf(bus.ledr), 16'h00FF);
      stepCycles(4);
      checkOutput("count_wrap", lowOf(bus.ledr), 16'h0000);
      stepCycles(4);
      checkOutput("count_01", lowOf(bus.ledr), 16'h0001);

      // Clear mid-count restarts value and prescaler.
      stepCycles(8);
      applyStimulus(5'b10000);
      stepCycles(1);
      checkOutput("clr_count", lowOf(bus.ledr), 16'h0000);
      checkOutput("clr_mode", modeOf(bus.ledr), 16'd2);
      stepCycles(3);
      checkOutput("clr_cnt_hold", lowOf(bus.ledr), 16'h0000);
      stepCycles(1);
      checkOutput("clr_cnt_tick", lowOf(bus.ledr), 16'h0001);

      // Pause, step twice, resume.
      stepCycles(3);
      applyStimulus(5'b00100);
      stepCycles(1);
      checkOutput("pause_run", runOf(bus.ledr), 16'd0);
      checkOutput("pause_val", lowOf(bus.ledr), 16'h0003);
      stepCycles(20);
      checkOutput("pause_frozen", lowOf(bus.ledr), 16'h0003);
      stepCycles(8);
      applyStimulus(5'b01000);
      stepCycles(1);
      checkOutput("step1", lowOf(bus.ledr), 16'h0004);
      stepCycles(8);
      applyStimulus(5'b01000);
      stepCycles(1);
      checkOutput("step2", lowOf(bus.ledr), 16'h0005);
      stepCycles(8);
      applyStimulus(5'b00100);
      stepCycles(1);
      checkOutput("resume_run", runOf(bus.ledr), 16'd1);
      checkOutput("resume_val", lowOf(bus.ledr), 16'h0005);
      stepCycles(TICK_DIV - PAUSE_CNT - 1);
      checkOutput("resume_wait", lowOf(bus.ledr), 16'h0005);
      stepCycles(1);
      checkOutput("resume_tick", lowOf(bus.ledr), 16'h0006);

      // Blink, wrap to PASS, previous wraps to BLINK, next+prev cancel.
      bus.sw = 8'h3C;
      stepCycles(8);
      applyStimulus(5'b00001);
      stepCycles(1);
      checkOutput("blink_mode", modeOf(bus.ledr), 16'd3);
      checkOutput("blink_off", lowOf(bus.ledr), 16'h0000);
      stepCycles(4);
      checkOutput("blink_on", lowOf(bus.ledr), 16'h003C);
      stepCycles(4);
      checkOutput("blink_off2", lowOf(bus.ledr), 16'h0000);
      stepCycles(8);
      applyStimulus(5'b00001);
      stepCycles(1);
      checkOutput("next_wrap", modeOf(bus.ledr), 16'd0);
      checkOutput("pass_3c", lowOf(bus.ledr), 16'h003C);
      stepCycles(8);
      applyStimulus(5'b00010);
      stepCycles(1);
      checkOutput("prev_wrap", modeOf(bus.ledr), 16'd3);
      stepCycles(8);
      applyStimulus(5'b00011);
      stepCycles(1);
      checkOutput("next_prev", modeOf(bus.ledr), 16'd3);

`ifdef LED_SCHED_DEBOUNCE_EN
      // A two-cycle glitch must not get through the debouncer.
      stepCycles(8);
      bus.btn[0] = 1'b1;
      stepCycles(2);
      bus.btn[0] = 1'b0;
      stepCycles(12);
      checkOutput("glitch", modeOf(bus.ledr), 16'd3);
`endif

      // Reset mid-blink with btn[0] held through reset release.
      stepCycles(3);
      bus.btn = 5'b00001;
      rst = 1'b0;
      stepCycles(2);
      checkOutput("rst_mid", bus.ledr, 16'h2000);
      rst = 1'b1;
      stepCycles(20);
      checkOutput("rst_held", bus.ledr, 16'h213C);
      bus.btn = '0;
      stepCycles(12);
      checkOutput("rst_release", bus.ledr, 16'h203C);
      applyStimulus(5'b00001);
      stepCycles(1);
      checkOutput("post_rst_press", modeOf(bus.ledr), 16'd1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
